// File: rtl/booth_multiplier.sv
// booth_multiplier: iterative radix-4 Booth multiplier, one digit per cycle, signed/unsigned.
// Define MUL_ACC_EN to add the acc input for multiply-accumulate into out.
module booth_multiplier #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   in1,
   input  logic [N-1:0]   in2,
   input  logic           signed_mode,
`ifdef MUL_ACC_EN
   input  logic           acc,
`endif
   output logic [2*N-1:0] out,
   output logic           busy,
   output logic           done
);
   localparam int E = N + 2;
   localparam int W = N + 4;
   localparam int CW = $clog2(N / 2 + 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0]            state;
   logic [W-1:0]          a, m, addend, sum;
   logic [E-1:0]          q;
   logic                  qm;
   logic [CW-1:0]         cnt;
   logic [2:0]            b;
   logic signed [W+E:0]   cat;
   logic [W+E:0]          sh;
   logic [2*N-1:0]        base;
`ifdef MUL_ACC_EN
   logic                  acc_r;
`endif
   assign busy = state == RUN;
   assign done = state == DONE;
   // {a,q,qm} is the Booth accumulator; q's low bits plus qm select the digit
   always_comb begin
      b = {q[1:0], qm};
      addend = (b == 3'b001 || b == 3'b010) ? m :
               (b == 3'b101 || b == 3'b110) ? -m :
               (b == 3'b011) ? m << 1 :
               (b == 3'b100) ? -(m << 1) : '0;
      sum = a + addend;
      cat = {sum, q, qm};
      sh = cat >>> 2;
`ifdef MUL_ACC_EN
      base = acc_r ? out : '0;
`else
      base = '0;
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         out <= '0;
         a <= '0;
         m <= '0;
         q <= '0;
         qm <= 1'b0;
         cnt <= '0;
`ifdef MUL_ACC_EN
         acc_r <= 1'b0;
`endif
      end else if (state != RUN && start) begin
         m <= signed_mode ? {{4{in1[N-1]}}, in1} : {4'b0, in1};
         q <= signed_mode ? {{2{in2[N-1]}}, in2} : {2'b0, in2};
         a <= '0;
         qm <= 1'b0;
         cnt <= '0;
`ifdef MUL_ACC_EN
         acc_r <= acc;
`endif
         state <= RUN;
      end else if (state == RUN) begin
         a <= sh[W+E:E+1];
         q <= sh[E:1];
         qm <= sh[0];
         cnt <= cnt + CW'(1);
         if (cnt == CW'(N / 2)) begin
            out <= sh[2*N:1] + base;
            state <= DONE;
         end
      end else begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed and random products checked through an expected-result queue.
module tb_booth_multiplier;
   localparam int N = 32;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, signed_mode = 1'b0, acc = 1'b0;
   logic [N-1:0] in1 = '0, in2 = '0;
   logic [2*N-1:0] out;
   logic busy, done;
   int cyc = 0, n_cmp = 0, n_err = 0, bcount;
   logic [63:0] exp_q[$];
   int cyc_q[$];
   logic done_prev = 1'b0;
   logic [63:0] model_out = '0;

   booth_multiplier #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
      .signed_mode(signed_mode),
`ifdef MUL_ACC_EN
      .acc(acc),
`endif
      .out(out), .busy(busy), .done(done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y, input logic sm);
      logic [63:0] xe, ye;
      xe = sm ? {{32{x[31]}}, x} : {32'b0, x};
      ye = sm ? {{32{y[31]}}, y} : {32'b0, y};
      return xe * ye;
   endfunction

   task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic sm, input logic ac, input logic push);
      logic [63:0] e;
      in1 = x;
      in2 = y;
      signed_mode = sm;
      acc = ac;
      start = 1'b1;
      e = prod(x, y, sm);
`ifdef MUL_ACC_EN
      if (ac) e = e + model_out;
`endif
      if (push) begin
         exp_q.push_back(e);
         cyc_q.push_back(cyc + 1);
         model_out = e;
      end
   endtask

   task automatic wait_empty();
      int k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("result_timeout", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sm, input logic ac);
      @(negedge clk);
      drive(x, y, sm, ac, 1'b1);
      @(negedge clk);
      start = 1'b0;
      wait_empty();
   endtask

   always @(negedge clk) begin
      if (done_prev) check("done_one_cycle", 64'(done), 64'(0));
      if (done === 1'b1) begin
         if (exp_q.size() == 0) check("spurious_done", 64'(done), 64'(0));
         else begin
            check("product", out, exp_q.pop_front());
            check("latency", 64'(cyc - cyc_q.pop_front()), 64'(17));
         end
      end
      done_prev = (done === 1'b1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset_out", out, 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      rst = 1'b0;
      run_op(32'h00087234, 32'h00000348, 1'b1, 1'b0);
      check("model_a", model_out, 64'h000000001BB6BAA0);
      run_op(32'h50647236, 32'h50612336, 1'b1, 1'b0);
      check("model_b", model_out, 64'h193DE4CED7437964);
      run_op(32'h00087234, 32'hFFFFFEFD, 1'b1, 1'b0);
      check("model_c", model_out, 64'hFFFFFFFFF7747564);
      run_op(32'h00087234, 32'hFFFFFEFD, 1'b0, 1'b0);
      check("model_u", model_out, 64'h00087233F7747564);
      run_op(32'hFFFFFEFD, 32'hFFFFFEFD, 1'b1, 1'b0);
      run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0);
      check("model_minneg", model_out, 64'h4000000000000000);
      run_op(32'hB887CAAF, 32'h00000000, 1'b1, 1'b0);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) run_op($urandom, $urandom, i[0], 1'b0);
      // back-to-back: start held high through RUN and DONE
      @(negedge clk);
      drive(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b1);
      bcount = 0;
      do begin
         @(negedge clk);
         bcount++;
      end while (done !== 1'b1 && bcount < 100);
      drive(32'h0000FFFF, 32'h80000001, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", 64'(busy), 64'(1));
      wait_empty();
      // start pulse in the middle of RUN must be ignored
      @(negedge clk);
      drive(32'hDEADBEEF, 32'h00C0FFEE, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      bcount = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy === 1'b1) bcount++;
         if (k == 3) begin
            in1 = $urandom;
            in2 = $urandom;
            signed_mode = ~signed_mode;
            start = 1'b1;
         end else if (k == 4) start = 1'b0;
         @(negedge clk);
      end
      check("busy_len", 64'(bcount), 64'(17));
      wait_empty();
      // reset during the fifth RUN cycle aborts without a done pulse
      @(negedge clk);
      drive(32'h0BADF00D, 32'h76543210, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("out_hold", out, model_out);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_out = '0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_out", out, 64'(0));
      repeat (30) @(negedge clk);
      run_op(32'h00000003, 32'hFFFFFFFB, 1'b1, 1'b0);
`ifdef MUL_ACC_EN
      run_op(32'h00000001, 32'h50647236, 1'b1, 1'b0);
      run_op(32'h00000001, 32'h00000001, 1'b1, 1'b1);
      check("acc_sum", model_out, 64'h0000000050647237);
`endif
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand width; N SHALL be even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin a multiply, sampled on the clk edge.
REQ-005 The block SHALL have ports in1 and in2, input, N bits each: multiplicand and multiplier.
REQ-006 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned operands.
REQ-007 The block SHALL have port out, output, 2N bits: the product.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking when out is valid.

Function
REQ-010 The block SHALL implement an iterative radix-4 Booth multiplier with states IDLE, RUN and DONE.
REQ-011 On an edge in IDLE or DONE where start=1, the block SHALL:
- capture in1, in2 and signed_mode;
- extend both operands to N+2 bits, sign-extended if signed_mode=1, otherwise zero-extended;
- clear the partial product and the iteration counter;
- enter RUN.
REQ-012 In RUN, each edge SHALL retire one Booth digit (0, ±1, ±2 times the multiplicand) and shift the accumulator right by 2 bits arithmetically.
REQ-013 RUN SHALL last exactly N/2+1 edges in both modes.
REQ-014 On the last RUN edge, the block SHALL load out with the low 2N bits of the exact product and enter DONE.
REQ-015 Latency: done SHALL be high in the cycle after edge N/2+1 counted from the start edge, which is 17 cycles for N=32.
REQ-016 done SHALL be high only while in DONE, for exactly one cycle.
REQ-017 From DONE, the block SHALL go to RUN if start=1, otherwise to IDLE, which allows back-to-back operations.
REQ-018 busy SHALL be 1 exactly in RUN.
REQ-019 start SHALL be ignored during RUN.
REQ-020 in1, in2 and signed_mode SHALL be don't-care after the start edge.
REQ-021 out SHALL hold its value from the DONE load until the next DONE load; it SHALL NOT show intermediate values.
REQ-022 Product rules:
- signed mode: out is the 2N-bit two's-complement product;
- unsigned mode: out is the 2N-bit unsigned product;
- no overflow is possible.
REQ-023 Boundary conditions:
- the most-negative operand squared, in signed mode, SHALL give +2^(2N-2);
- an operand of 0 SHALL give 0 with the normal latency, with no early exit.

Reset
REQ-024 When rst=1 on an edge, the block SHALL enter IDLE and set out=0, busy=0, done=0, and clear the counter and accumulator; rst SHALL take priority over start.
REQ-025 A reset during RUN SHALL abort the operation; no done pulse SHALL follow for it.

Configuration
REQ-026 The macro MUL_ACC_EN SHALL select multiply-accumulate support.
REQ-027 With MUL_ACC_EN defined:
- input port acc (1 bit) SHALL exist, sampled on the start edge;
- if acc=1, the DONE load SHALL set out to the previous out plus the new product, modulo 2^(2N);
- if acc=0, the DONE load SHALL behave as in REQ-014;
- the addition SHALL take place in the final RUN edge and SHALL NOT add latency.
REQ-028 Without MUL_ACC_EN, port acc SHALL NOT exist and out SHALL always be loaded with the product alone.

Verification
REQ-029 Basic and signed products (N=32, signed_mode=1):
- in1=0x00087234, in2=0x00000348 -> out=0x000000001BB6BAA0;
- in1=0x50647236, in2=0x50612336 -> out=0x193DE4CED7437964;
- in1=0x00087234, in2=0xFFFFFEFD -> out=0xFFFFFFFFF7747564;
- done pulses for 1 cycle, 17 cycles after start.
REQ-030 Mode: in1=0x00087234, in2=0xFFFFFEFD with signed_mode=0 -> out=0x00087233F7747564.
REQ-031 Boundaries:
- 0xFFFFFEFD x 0xFFFFFEFD, signed -> out=0x0000000000010609;
- 0x80000000 x 0x80000000, signed -> out=0x4000000000000000;
- 0xB887CAAF x 0x00000000 -> out=0, with the full latency.
REQ-032 Handshake:
- start held high in DONE -> the next operation starts with no idle cycle;
- start pulsed during RUN -> ignored, and busy stays high for 17 cycles in total.
REQ-033 Reset: rst asserted on the 5th RUN cycle -> next cycle busy=0, done=0, out=0, and no done pulse for the aborted operation.
REQ-034 Accumulate (MUL_ACC_EN only): 1 x 0x50647236 with acc=0, then 1 x 1 with acc=1 -> out=0x0000000050647237.
